// File: rtl/uart_rx_wr_if.sv
// FIFO write-port bundle between the serial receiver and the async FIFO.
// The receiver drives wren/wdata and observes wfull.
interface uart_rx_wr_if #(
    parameter int dsize = 8
);
    logic             wren;
    logic [dsize-1:0] wdata;
    logic             wfull;

    modport master (output wren, output wdata, input wfull);
    modport slave  (input wren, input wdata, output wfull);
endinterface

// File: rtl/uart_rx_wr.sv
// 8N1 serial receiver feeding the async FIFO write port through a
// one-entry hold buffer, with framing-error and overrun pulses.
module uart_rx_wr #(
    parameter int dsize    = 8,
    parameter int baud_div = 16
) (
    input  logic         wclk,
    input  logic         wrstn,
    input  logic         rxd,
    uart_rx_wr_if.master wr,
    output logic         frame_err,
    output logic         overrun,
    output logic         busy
);
    localparam int cw = $clog2(baud_div);
    localparam int iw = $clog2(dsize + 1);
    localparam logic [cw-1:0] half_m1  = cw'(baud_div / 2 - 1);
    localparam logic [cw-1:0] full_m1  = cw'(baud_div - 1);
    localparam logic [iw-1:0] last_idx = iw'(dsize - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic             rxd_m;
    logic             rxd_s;
    logic [1:0]       state;
    logic [cw-1:0]    cnt;
    logic [iw-1:0]    idx;
    logic [dsize-1:0] shreg;
    logic [dsize-1:0] hold_data;
    logic             hold_vld;
    logic             take;
    logic             stop_ok;

    // Idle-high synchronizer: a reset never looks like a start bit
    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (cnt != '0)
                cnt <= cnt - cw'(1);
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        cnt   <= half_m1;
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == '0) begin
                        if (rxd_s) begin
                            state <= IDLE;
                        end else begin
                            cnt   <= full_m1;
                            idx   <= '0;
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        shreg <= {rxd_s, shreg[dsize-1:1]};
                        idx   <= idx + iw'(1);
                        cnt   <= full_m1;
                        if (idx == last_idx)
                            state <= STOP;
                    end
                end
                STOP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        if (!rxd_s)
                            frame_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stop_ok = (state == STOP) && (cnt == '0) && rxd_s;
    assign take    = hold_vld & ~wr.wfull;

    // A write and a new delivery on the same edge is a drain-and-refill
    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            hold_data <= '0;
            hold_vld  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (stop_ok && (!hold_vld || take)) begin
                hold_data <= shreg;
                hold_vld  <= 1'b1;
            end else begin
                if (take)
                    hold_vld <= 1'b0;
                if (stop_ok)
                    overrun <= 1'b1;
            end
        end
    end

    assign wr.wren  = take;
    assign wr.wdata = hold_data;
    assign busy     = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_wr.sv
// Directed and randomized frames for uart_rx_wr, checked against a
// frame-level prediction of writes, framing errors and overruns.
module tb_uart_rx_wr;
    localparam int dsize    = 8;
    localparam int baud_div = 16;
    // rxd changes after edge n; two synchronizer edges, then the FSM sees it at n+3
    localparam int e_off    = 3;
    localparam int s_off    = e_off + baud_div / 2 + (dsize + 1) * baud_div;
    localparam int busy_len = s_off - e_off;

    logic wclk = 1'b0;
    logic wrstn;
    logic rxd;
    logic frame_err;
    logic overrun;
    logic busy;

    uart_rx_wr_if #(.dsize(dsize)) wr_if ();

    uart_rx_wr #(.dsize(dsize), .baud_div(baud_div)) dut (
        .wclk      (wclk),
        .wrstn     (wrstn),
        .rxd       (rxd),
        .wr        (wr_if.master),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 wclk = ~wclk;

    int cyc = 0;
    always @(posedge wclk) cyc <= cyc + 1;

    int               got_wr_c[$];
    logic [dsize-1:0] got_wr_d[$];
    int               got_fe[$];
    int               got_ov[$];
    int               busy_cnt = 0;
    int               both_cnt = 0;

    always @(negedge wclk) begin
        if (wr_if.wren === 1'b1) begin
            got_wr_c.push_back(cyc);
            got_wr_d.push_back(wr_if.wdata);
        end
        if (frame_err === 1'b1) got_fe.push_back(cyc);
        if (overrun === 1'b1) got_ov.push_back(cyc);
        if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
        if (frame_err === 1'b1 && overrun === 1'b1) both_cnt <= both_cnt + 1;
    end

    int n_assert = 0;
    int n_fail   = 0;

    int               exp_wr_c[$];
    logic [dsize-1:0] exp_wr_d[$];
    int               exp_fe[$];
    int               exp_ov[$];
    logic             m_vld;
    logic [dsize-1:0] m_byte;
    int wr_base, fe_base, ov_base, busy_base;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge wclk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [dsize-1:0] b, input logic stop, output int n);
        n = cyc;
        rxd = 1'b0;
        tick(baud_div);
        for (int k = 0; k < dsize; k++) begin
            rxd = b[k];
            tick(baud_div);
        end
        rxd = stop;
        tick(baud_div);
        rxd = 1'b1;
    endtask

    // Frame-level outcome: the byte is written one cycle after its stop sample,
    // parked while the FIFO is full, or dropped if something is already parked.
    task automatic predict(input logic [dsize-1:0] b, input logic stop, input int n, input logic full);
        int s;
        s = n + s_off;
        if (!stop) begin
            exp_fe.push_back(s);
        end else if (m_vld) begin
            exp_ov.push_back(s);
        end else if (full) begin
            m_vld  = 1'b1;
            m_byte = b;
        end else begin
            exp_wr_d.push_back(b);
            exp_wr_c.push_back(s);
        end
    endtask

    task automatic release_full(input int d);
        if (m_vld) begin
            exp_wr_d.push_back(m_byte);
            exp_wr_c.push_back(d);
            m_vld = 1'b0;
        end
    endtask

    task automatic begin_test();
        wr_base   = got_wr_c.size();
        fe_base   = got_fe.size();
        ov_base   = got_ov.size();
        busy_base = busy_cnt;
        exp_wr_c.delete();
        exp_wr_d.delete();
        exp_fe.delete();
        exp_ov.delete();
        m_vld = 1'b0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_n_wren"}, got_wr_c.size() - wr_base, exp_wr_c.size());
        for (int i = 0; i < exp_wr_c.size() && wr_base + i < got_wr_c.size(); i++) begin
            check($sformatf("%s_wdata%0d", tag, i), got_wr_d[wr_base + i], exp_wr_d[i]);
            check($sformatf("%s_wcyc%0d", tag, i), got_wr_c[wr_base + i], exp_wr_c[i]);
        end
        check({tag, "_n_ferr"}, got_fe.size() - fe_base, exp_fe.size());
        for (int i = 0; i < exp_fe.size() && fe_base + i < got_fe.size(); i++)
            check($sformatf("%s_ferr_cyc%0d", tag, i), got_fe[fe_base + i], exp_fe[i]);
        check({tag, "_n_ovr"}, got_ov.size() - ov_base, exp_ov.size());
        for (int i = 0; i < exp_ov.size() && ov_base + i < got_ov.size(); i++)
            check($sformatf("%s_ovr_cyc%0d", tag, i), got_ov[ov_base + i], exp_ov[i]);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wren"}, wr_if.wren, 1'b0);
        check({tag, "_wdata"}, wr_if.wdata, '0);
        check({tag, "_ferr"}, frame_err, 1'b0);
        check({tag, "_ovr"}, overrun, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        int n, d, gap;
        logic [dsize-1:0] b;

        wrstn = 1'b0;
        rxd = 1'b1;
        wr_if.wfull = 1'b0;
        m_vld = 1'b0;
        m_byte = '0;
        tick(3);
        @(negedge wclk);
        check_outputs_zero("reset");
        tick(1);
        wrstn = 1'b1;
        tick(5);

        begin_test();
        send_frame(8'hA5, 1'b1, n);
        predict(8'hA5, 1'b1, n, 1'b0);
        tick(10);
        compare_all("single");
        check("single_busy_cycles", busy_cnt - busy_base, busy_len);

        begin_test();
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        tick(30);
        compare_all("glitch");
        check("glitch_busy_cycles", busy_cnt - busy_base, baud_div / 2);

        begin_test();
        send_frame(8'h3C, 1'b0, n);
        predict(8'h3C, 1'b0, n, 1'b0);
        tick(30);
        compare_all("frame_err");

        begin_test();
        wr_if.wfull = 1'b1;
        send_frame(8'h11, 1'b1, n);
        predict(8'h11, 1'b1, n, 1'b1);
        send_frame(8'h22, 1'b1, n);
        predict(8'h22, 1'b1, n, 1'b1);
        b = dsize'($urandom);
        send_frame(b, 1'b0, n);
        predict(b, 1'b0, n, 1'b1);
        tick(30);
        d = cyc;
        wr_if.wfull = 1'b0;
        release_full(d);
        tick(10);
        compare_all("backpressure");

        begin_test();
        for (int i = 1; i <= 4; i++) begin
            send_frame(dsize'(i), 1'b1, n);
            predict(dsize'(i), 1'b1, n, 1'b0);
        end
        tick(10);
        compare_all("b2b");
        if (got_wr_c.size() >= wr_base + 2)
            check("b2b_spacing", got_wr_c[wr_base + 1] - got_wr_c[wr_base], 10 * baud_div);

        begin_test();
        for (int i = 0; i < 6; i++) begin
            gap = int'($urandom_range(0, 30));
            tick(gap);
            b = dsize'($urandom);
            send_frame(b, 1'b1, n);
            predict(b, 1'b1, n, 1'b0);
        end
        tick(10);
        compare_all("random");

        begin_test();
        wr_if.wfull = 1'b1;
        send_frame(8'hC3, 1'b1, n);
        predict(8'hC3, 1'b1, n, 1'b1);
        tick(5);
        fork
            send_frame(8'hFF, 1'b1, n);
            begin
                tick(4 * baud_div + 5);
                wrstn = 1'b0;
                @(negedge wclk);
                check_outputs_zero("midreset");
                tick(3);
                wrstn = 1'b1;
            end
        join
        m_vld = 1'b0;
        wr_if.wfull = 1'b0;
        tick(20);
        send_frame(8'h5A, 1'b1, n);
        predict(8'h5A, 1'b1, n, 1'b0);
        tick(10);
        compare_all("midreset");

        check("ferr_ovr_exclusive", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
